countdown_timer_multi: RTL and testbench
========================================

Name: countdown_timer_multi

Overview:
Generalised, parametrised countdown timer for the number-game datapath, clocked from the half-second tick.
- Merges the flash-countdown, plain seconds countdown and life-progress behaviours into one block.
- Adds runtime load, pause/resume, a scaled progress bar and a done/expired handshake.
- Feeds the sevenseg/LED display logic and the game-control FSM.

Parameters:
CNT_W, 8, width of the seconds counter and of load_secs.
PROG_MAX, 10, full-scale value of the progress output.
PROG_W, 5, width of progress; must hold PROG_MAX.

Ports:
halfsecclk  input  1  half-second clock; all state changes on its rising edge.
resetn  input  1  asynchronous, active-low reset.
load  input  1  synchronous load request, sampled on a clock edge.
load_secs  input  CNT_W  countdown length in seconds, captured on load.
run  input  1  1 = count, 0 = pause.
flash_en  input  1  1 = status flashes while counting.
secs_left  output  CNT_W  remaining whole seconds.
half  output  1  half-second phase within the current second.
status  output  1  display enable (1 = sevensegs/LEDs on).
progress  output  PROG_W  ceil(secs_left*PROG_MAX/total), range PROG_MAX..0.
done  output  1  one-cycle pulse on expiry.
expired  output  1  level; set on expiry, held until next load.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - secs_left=0, half=0, status=1, progress=0, done=0, expired=0.
  - Internal total=0.
- States: IDLE, RUN, PAUSE, EXPIRED.
- load (highest priority, accepted in any state):
  - secs_left<=load_secs, total<=load_secs, half<=0, done<=0, status<=1.
  - If load_secs>0: progress<=PROG_MAX, expired<=0; next state RUN if run=1, else PAUSE.
  - If load_secs==0: progress<=0, expired<=1, state EXPIRED, no done pulse.
- IDLE: holds all outputs; leaves only via load.
- RUN, run=1, per edge:
  - If half=0: half<=1.
  - Else: half<=0 and secs_left<=secs_left-1, so each second spans 2 edges.
  - progress is recomputed on every decrement from the new secs_left.
  - Product secs_left*PROG_MAX is computed at CNT_W+PROG_W bits. Ceil uses (n*PROG_MAX + total-1)/total.
  - Decrement reaching 0: same edge sets progress=0, expired=1, done=1, half=0; next state EXPIRED.
- RUN, run=0: go to PAUSE with no change to secs_left or half. That edge does not count.
- PAUSE:
  - Holds secs_left, half and progress; status=1.
  - run=1 moves to RUN. The first counting edge is the one after the transition edge.
- EXPIRED:
  - secs_left=0, progress=0, expired=1; status=1 without the optional feature.
  - done clears on the edge after it was set, so it is exactly one cycle wide.
- status in RUN:
  - flash_en=1: status=~half, i.e. on for the first half of each second and off for the second half.
  - flash_en=0: status=1.
- secs_left never underflows; no decrement occurs at 0.
- Reset mid-count: immediate return to reset values, asynchronously.

Optional Feature:
Macro COUNTDOWN_EXPIRE_BLINK_EN.
- Defined: in EXPIRED, status toggles on every halfsecclk edge, starting at 0 on the edge after entry. This gives a visible "time up" blink.
- Undefined: status is a steady 1 in EXPIRED.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset, then load=1 with load_secs=3, run=1, flash_en=1 -> edges 2/4/6 give secs_left 2/1/0 and progress 7/4/0. done=1 on edge 6 only; expired=1 from edge 6. status pattern 1,0,1,0,1,0 over edges 1-6.
2. load_secs=5 with run=1; drop run after edge 3 for 4 edges, then raise it -> secs_left holds 4 and half holds 1 during the pause. Counting resumes, reaching 0 exactly 7 counting edges after the pause ends.
3. load_secs=0 -> next cycle: expired=1, progress=0, done stays 0, state EXPIRED.
4. Assert load (load_secs=2) mid-count at secs_left=4 -> secs_left=2, half=0, progress=10, expired=0. A second load issued while EXPIRED restarts the timer.
5. Assert resetn=0 asynchronously mid-RUN at secs_left=6 -> all outputs return immediately to reset values, with status=1 and progress=0.
6. Build with COUNTDOWN_EXPIRE_BLINK_EN and load_secs=1 -> after expiry, status reads 0,1,0,1 on successive edges. Build without the macro -> status stays constantly 1.

Source files
------------

// File: rtl/countdown_timer_multi.sv
// countdown_timer_multi: half-second-clocked countdown with pause, scaled progress and done/expired handshake.
// Optional COUNTDOWN_EXPIRE_BLINK_EN makes status blink while expired.
module countdown_timer_multi #(
    parameter int CNT_W    = 8,
    parameter int PROG_MAX = 10,
    parameter int PROG_W   = 5
) (
    input  logic              halfsecclk,
    input  logic              resetn,
    input  logic              load,
    input  logic [CNT_W-1:0]  load_secs,
    input  logic              run,
    input  logic              flash_en,
    output logic [CNT_W-1:0]  secs_left,
    output logic              half,
    output logic              status,
    output logic [PROG_W-1:0] progress,
    output logic              done,
    output logic              expired
);
    localparam int PW = CNT_W + PROG_W;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  secs_q, total_q, secs_d;
    logic              half_q, status_q, done_q, exp_q;
    logic [PROG_W-1:0] prog_q, prog_d;
    logic [PW-1:0]     num_d;

    // Progress is ceil(secs*PROG_MAX/total), evaluated on the decremented count.
    always_comb begin
        secs_d = secs_q - CNT_W'(1);
        num_d  = PW'(secs_d) * PW'(PROG_MAX) + PW'(total_q) - PW'(1);
        prog_d = (total_q == '0) ? '0 : PROG_W'(num_d / PW'(total_q));
    end

`ifdef COUNTDOWN_EXPIRE_BLINK_EN
    logic ph_q;
    always_ff @(posedge halfsecclk or negedge resetn) begin
        if (!resetn) ph_q <= 1'b0;
        else         ph_q <= (state_q == EXPIRED && !load) ? ~ph_q : 1'b0;
    end
`endif

    always_ff @(posedge halfsecclk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            secs_q   <= '0;
            total_q  <= '0;
            half_q   <= 1'b0;
            status_q <= 1'b1;
            prog_q   <= '0;
            done_q   <= 1'b0;
            exp_q    <= 1'b0;
        end else if (load) begin
            secs_q   <= load_secs;
            total_q  <= load_secs;
            half_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= 1'b1;
            if (load_secs != '0) begin
                prog_q  <= PROG_W'(PROG_MAX);
                exp_q   <= 1'b0;
                state_q <= run ? RUN : PAUSE;
            end else begin
                prog_q  <= '0;
                exp_q   <= 1'b1;
                state_q <= EXPIRED;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (!run) begin
                        state_q  <= PAUSE;
                        status_q <= 1'b1;
                    end else begin
                        status_q <= flash_en ? ~half_q : 1'b1;
                        half_q   <= ~half_q;
                        if (half_q) begin
                            secs_q <= secs_d;
                            prog_q <= prog_d;
                            if (secs_d == '0) begin
                                exp_q   <= 1'b1;
                                done_q  <= 1'b1;
                                state_q <= EXPIRED;
                            end
                        end
                    end
                end
                PAUSE: begin
                    status_q <= 1'b1;
                    if (run) state_q <= RUN;
                end
                EXPIRED: begin
                    secs_q <= '0;
                    prog_q <= '0;
                    exp_q  <= 1'b1;
`ifdef COUNTDOWN_EXPIRE_BLINK_EN
                    status_q <= ph_q;
`else
                    status_q <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign secs_left = secs_q;
    assign half      = half_q;
    assign status    = status_q;
    assign progress  = prog_q;
    assign done      = done_q;
    assign expired   = exp_q;
endmodule

// File: tb/tb_countdown_timer_multi.sv
// tb_countdown_timer_multi: random and directed stimulus checked against a half-tick-counting reference model.
module tb_countdown_timer_multi;
    localparam int CNT_W = 8, PROG_MAX = 10, PROG_W = 5;
    localparam int M_IDLE = 0, M_CNT = 1, M_PAU = 2, M_EXP = 3;

    logic              halfsecclk, resetn, load, run, flash_en;
    logic [CNT_W-1:0]  load_secs, secs_left;
    logic              half, status, done, expired;
    logic [PROG_W-1:0] progress;

    countdown_timer_multi #(.CNT_W(CNT_W), .PROG_MAX(PROG_MAX), .PROG_W(PROG_W)) dut (
        .halfsecclk(halfsecclk), .resetn(resetn), .load(load), .load_secs(load_secs),
        .run(run), .flash_en(flash_en), .secs_left(secs_left), .half(half),
        .status(status), .progress(progress), .done(done), .expired(expired)
    );

    initial begin
        halfsecclk = 0;
        forever #5 halfsecclk = ~halfsecclk;
    end

    int total = 0, bad = 0;
    // The model tracks remaining half-seconds; seconds and phase derive from it.
    int m_mode, m_halves, m_total;
    bit m_status, m_done, m_exp, m_ph;

    function automatic int m_secs();
        return (m_halves + 1) / 2;
    endfunction

    function automatic int m_prog();
        if (m_mode == M_EXP || m_total == 0) return 0;
        return (m_secs() * PROG_MAX + m_total - 1) / m_total;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_halves = 0; m_total = 0;
        m_status = 1; m_done = 0; m_exp = 0; m_ph = 0;
    endtask

    task automatic model_step();
        if (load) begin
            m_total = load_secs; m_halves = 2 * load_secs; m_done = 0; m_status = 1; m_ph = 0;
            if (load_secs != 0) begin
                m_exp = 0; m_mode = run ? M_CNT : M_PAU;
            end else begin
                m_exp = 1; m_mode = M_EXP;
            end
        end else begin
            m_done = 0;
            if (m_mode == M_CNT) begin
                if (!run) begin
                    m_mode = M_PAU; m_status = 1;
                end else begin
                    m_status = flash_en ? (m_halves % 2 == 0) : 1'b1;
                    m_halves--;
                    if (m_halves == 0) begin
                        m_mode = M_EXP; m_exp = 1; m_done = 1; m_ph = 0;
                    end
                end
            end else if (m_mode == M_PAU) begin
                m_status = 1;
                if (run) m_mode = M_CNT;
            end else if (m_mode == M_EXP) begin
`ifdef COUNTDOWN_EXPIRE_BLINK_EN
                m_status = m_ph;
                m_ph = !m_ph;
`else
                m_status = 1;
`endif
            end
        end
    endtask

    task automatic compare();
        chk("secs_left", int'(secs_left), m_secs());
        chk("half", int'(half), m_halves % 2);
        chk("status", int'(status), int'(m_status));
        chk("progress", int'(progress), m_prog());
        chk("done", int'(done), int'(m_done));
        chk("expired", int'(expired), int'(m_exp));
    endtask

    task automatic step();
        @(posedge halfsecclk);
        model_step();
        #1;
        compare();
    endtask

    task automatic async_reset();
        #1 resetn = 0;
        #1 model_reset();
        compare();
        chk("rst_secs", int'(secs_left), 0);
        chk("rst_status", int'(status), 1);
        chk("rst_progress", int'(progress), 0);
        #1 resetn = 1;
    endtask

    task automatic do_load(int secs, bit r);
        load = 1; load_secs = CNT_W'(secs); run = r;
        step();
        load = 0;
    endtask

    int e_secs[6] = '{3, 2, 2, 1, 1, 0};
    int e_prog[6] = '{10, 7, 7, 4, 4, 0};
    int e_stat[6] = '{1, 0, 1, 0, 1, 0};
    int e_done[6] = '{0, 0, 0, 0, 0, 1};

    initial begin
        resetn = 0; load = 0; load_secs = 0; run = 0; flash_en = 0;
        model_reset();
        #12;
        compare();
        chk("reset_status", int'(status), 1);
        chk("reset_expired", int'(expired), 0);
        #1 resetn = 1;

        // Basic 3-second flash countdown
        flash_en = 1;
        do_load(3, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t1_secs", int'(secs_left), e_secs[i]);
            chk("t1_prog", int'(progress), e_prog[i]);
            chk("t1_status", int'(status), e_stat[i]);
            chk("t1_done", int'(done), e_done[i]);
        end
        chk("t1_expired", int'(expired), 1);
        step();
        chk("t1_done_clear", int'(done), 0);
`ifdef COUNTDOWN_EXPIRE_BLINK_EN
        chk("t1_blink0", int'(status), 0);
`else
        chk("t1_steady", int'(status), 1);
`endif

        // Pause and resume
        flash_en = 0;
        do_load(5, 1);
        for (int i = 0; i < 3; i++) step();
        run = 0;
        for (int i = 0; i < 4; i++) step();
        chk("t2_pause_secs", int'(secs_left), 4);
        chk("t2_pause_half", int'(half), 1);
        run = 1;
        step();
        for (int i = 0; i < 6; i++) step();
        chk("t2_secs_before", int'(secs_left), 1);
        step();
        chk("t2_secs_zero", int'(secs_left), 0);
        chk("t2_done", int'(done), 1);

        // Zero-length load
        do_load(0, 1);
        chk("t3_expired", int'(expired), 1);
        chk("t3_done", int'(done), 0);
        chk("t3_prog", int'(progress), 0);

        // Reload mid-count, then reload from expired
        do_load(9, 1);
        for (int i = 0; i < 40 && secs_left != 4; i++) step();
        chk("t4_reached4", int'(secs_left), 4);
        do_load(2, 1);
        chk("t4_secs", int'(secs_left), 2);
        chk("t4_half", int'(half), 0);
        chk("t4_prog", int'(progress), 10);
        chk("t4_exp", int'(expired), 0);
        for (int i = 0; i < 4; i++) step();
        chk("t4_exp_end", int'(expired), 1);
        do_load(1, 1);
        chk("t4_restart", int'(secs_left), 1);
        chk("t4_restart_exp", int'(expired), 0);
        // Blink after 1-second expiry
        for (int i = 0; i < 2; i++) step();
        chk("t6_done", int'(done), 1);
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef COUNTDOWN_EXPIRE_BLINK_EN
            chk("t6_blink", int'(status), i % 2);
`else
            chk("t6_steady", int'(status), 1);
`endif
        end

        // Async reset mid-count
        do_load(9, 1);
        for (int i = 0; i < 40 && secs_left != 6; i++) step();
        chk("t5_reached6", int'(secs_left), 6);
        async_reset();
        chk("t5_expired", int'(expired), 0);
        chk("t5_half", int'(half), 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            load = ($urandom_range(0, 15) == 0);
            load_secs = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 255)) : CNT_W'($urandom_range(0, 6));
            run = ($urandom_range(0, 4) != 0);
            flash_en = 1'($urandom_range(0, 1));
            step();
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
